// File: rtl/front_spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : front_spi_arb_pkg
// Description : Shared front-panel definitions for the SPI arbiter: FSM state
//               encoding, requester IDs, default timing parameters and the
//               SPI word type.
// Revision    : 1.0 - initial release
// ============================================================================
package front_spi_arb_pkg;

    // SPI word width and type
    localparam int c_data_w = 24;
    typedef logic [c_data_w-1:0] spi_word_t;

    // Requester IDs
    localparam logic c_id_lcd = 1'b0;
    localparam logic c_id_sw  = 1'b1;

    // Default timing parameters
    localparam int c_def_timeout_cyc = 1024;
    localparam int c_def_gap_cyc     = 4;

    // Arbiter FSM state encoding
    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_load      = 3'd1;
    localparam logic [2:0] c_st_start     = 3'd2;
    localparam logic [2:0] c_st_wait_low  = 3'd3;
    localparam logic [2:0] c_st_wait_high = 3'd4;
    localparam logic [2:0] c_st_done      = 3'd5;
    localparam logic [2:0] c_st_gap       = 3'd6;

endpackage
`default_nettype wire

// File: rtl/front_spi_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : front_rr_arb2
// Description : Two-way round-robin grant. A lone requester is granted; on a
//               tie the requester that was not served last wins.
// Ports       : req[1:0] - request vector, indexed by requester ID
//               last     - ID of the requester served last
//               grant    - ID of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module front_rr_arb2
    import front_spi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = c_id_lcd;
        if (req[c_id_lcd] && req[c_id_sw]) begin
            grant = ~last;
        end else if (req[c_id_sw]) begin
            grant = c_id_sw;
        end else begin
            grant = c_id_lcd;
        end
    end

endmodule
`default_nettype wire

// File: rtl/front_spi_arb.sv
`default_nettype none
// ============================================================================
// Module      : front_spi_arb
// Description : Shares one SPI master between the LCD and switch requesters.
//               Round-robin arbitration, per-requester chip selects gated
//               from the master's CS, CS-wait timeout with sticky error flag
//               and an enforced idle gap between transactions.
// Ports       : i_clk / i_rst (sync, active-low)
//               i_lcd_req, i_lcd_mosi, o_lcd_done - LCD requester
//               i_sw_req,  i_sw_mosi,  o_sw_done  - switch requester
//               o_rx_data                          - received word
//               o_spi_start, o_mosi_data, i_miso_data, i_spi_cs - SPI master
//               o_lcd_cs, o_sw_cs                  - device chip selects
//               o_busy, o_timeout_err, i_err_clear - status
// Revision    : 1.0 - initial release
// ============================================================================
module front_spi_arb
    import front_spi_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = c_def_timeout_cyc,
    parameter int GAP_CYC     = c_def_gap_cyc
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_lcd_req,
    input  logic [c_data_w-1:0] i_lcd_mosi,
    output logic                o_lcd_done,
    input  logic                i_sw_req,
    input  logic [c_data_w-1:0] i_sw_mosi,
    output logic                o_sw_done,
    output logic [c_data_w-1:0] o_rx_data,
    output logic                o_spi_start,
    output logic [c_data_w-1:0] o_mosi_data,
    input  logic [c_data_w-1:0] i_miso_data,
    input  logic                i_spi_cs,
    output logic                o_lcd_cs,
    output logic                o_sw_cs,
    output logic                o_busy,
    output logic                o_timeout_err,
    input  logic                i_err_clear
);

    // One counter serves both the CS-wait timeout and the inter-transaction gap
    localparam int c_cnt_max = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_to_last  = c_cnt_w'(TIMEOUT_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last = c_cnt_w'(GAP_CYC - 1);

    logic [2:0]         r_state;
    logic               r_owner;
    logic               r_last;
    spi_word_t          r_mosi_data;
    spi_word_t          r_rx_data;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_timeout_err;

    logic w_grant;
    logic w_in_txn;
    logic w_to_hit;
    logic w_to_set;

    front_rr_arb2 u_rr_arb (
        .req   ({i_sw_req, i_lcd_req}),
        .last  (r_last),
        .grant (w_grant)
    );

    // Timeout fires only if the awaited CS level has not arrived this cycle
    assign w_to_hit = (r_cnt == c_to_last);
    assign w_to_set = ((r_state == c_st_wait_low)  &&  i_spi_cs && w_to_hit) ||
                      ((r_state == c_st_wait_high) && !i_spi_cs && w_to_hit);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= c_st_idle;
            r_owner       <= c_id_lcd;
            r_last        <= c_id_sw;
            r_mosi_data   <= '0;
            r_rx_data     <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (i_lcd_req || i_sw_req) begin
                        r_owner     <= w_grant;
                        r_last      <= w_grant;
                        r_mosi_data <= (w_grant == c_id_sw) ? i_sw_mosi : i_lcd_mosi;
                        r_state     <= c_st_load;
                    end
                end
                c_st_load: begin
                    r_state <= c_st_start;
                end
                c_st_start: begin
                    r_cnt   <= '0;
                    r_state <= c_st_wait_low;
                end
                c_st_wait_low: begin
                    if (!i_spi_cs) begin
                        r_cnt   <= '0;
                        r_state <= c_st_wait_high;
                    end else if (w_to_hit) begin
                        r_rx_data <= '0;
                        r_state   <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                c_st_wait_high: begin
                    // Capture on the edge into DONE so the word is valid
                    // during the done pulse
                    if (i_spi_cs) begin
                        r_rx_data <= i_miso_data;
                        r_state   <= c_st_done;
                    end else if (w_to_hit) begin
                        r_rx_data <= '0;
                        r_state   <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                c_st_done: begin
                    r_cnt   <= '0;
                    r_state <= c_st_gap;
                end
                c_st_gap: begin
                    if (r_cnt == c_gap_last) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase

            // Set has priority over clear
            if (w_to_set) begin
                r_timeout_err <= 1'b1;
            end else if (i_err_clear) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign w_in_txn = (r_state == c_st_load)     || (r_state == c_st_start) ||
                      (r_state == c_st_wait_low) || (r_state == c_st_wait_high);

    // Only the owner's CS ever follows the master, so both can never be low
    assign o_lcd_cs = (w_in_txn && (r_owner == c_id_lcd)) ? i_spi_cs : 1'b1;
    assign o_sw_cs  = (w_in_txn && (r_owner == c_id_sw))  ? i_spi_cs : 1'b1;

    assign o_spi_start   = (r_state == c_st_start);
    assign o_lcd_done    = (r_state == c_st_done) && (r_owner == c_id_lcd);
    assign o_sw_done     = (r_state == c_st_done) && (r_owner == c_id_sw);
    assign o_busy        = (r_state != c_st_idle);
    assign o_mosi_data   = r_mosi_data;
    assign o_rx_data     = r_rx_data;
    assign o_timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_front_spi_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_front_spi_arb
// Description : Self-checking bench for front_spi_arb. Directed scenarios plus
//               randomized transactions; owner and data expectations come from
//               a round-robin reference model and the SPI model driven here.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_front_spi_arb;
    import front_spi_arb_pkg::*;

    localparam int TO  = 1024;
    localparam int GAP = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_lcd_req;
    logic [23:0] i_lcd_mosi;
    logic        o_lcd_done;
    logic        i_sw_req;
    logic [23:0] i_sw_mosi;
    logic        o_sw_done;
    logic [23:0] o_rx_data;
    logic        o_spi_start;
    logic [23:0] o_mosi_data;
    logic [23:0] i_miso_data;
    logic        i_spi_cs;
    logic        o_lcd_cs;
    logic        o_sw_cs;
    logic        o_busy;
    logic        o_timeout_err;
    logic        i_err_clear;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    front_spi_arb #(
        .TIMEOUT_CYC (TO),
        .GAP_CYC     (GAP)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_lcd_req     (i_lcd_req),
        .i_lcd_mosi    (i_lcd_mosi),
        .o_lcd_done    (o_lcd_done),
        .i_sw_req      (i_sw_req),
        .i_sw_mosi     (i_sw_mosi),
        .o_sw_done     (o_sw_done),
        .o_rx_data     (o_rx_data),
        .o_spi_start   (o_spi_start),
        .o_mosi_data   (o_mosi_data),
        .i_miso_data   (i_miso_data),
        .i_spi_cs      (i_spi_cs),
        .o_lcd_cs      (o_lcd_cs),
        .o_sw_cs       (o_sw_cs),
        .o_busy        (o_busy),
        .o_timeout_err (o_timeout_err),
        .i_err_clear   (i_err_clear)
    );

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%06h required 0x%06h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge i_clk);
    endtask

    // Round-robin reference: a lone requester wins, a tie goes to the one not served last
    function automatic logic ref_pick(input logic l, input logic s, input logic last_served);
        if (l && !s) return c_id_lcd;
        if (s && !l) return c_id_sw;
        return (last_served == c_id_lcd) ? c_id_sw : c_id_lcd;
    endfunction

    // Chip-select invariants every cycle out of reset
    always @(negedge i_clk) begin
        if (i_rst === 1'b1) begin
            chk_b("cs_never_both_low", o_lcd_cs | o_sw_cs, 1'b1);
            if (o_busy === 1'b0) begin
                chk_b("idle_lcd_cs", o_lcd_cs, 1'b1);
                chk_b("idle_sw_cs", o_sw_cs, 1'b1);
            end
        end
    end

    task automatic check_reset_state();
        chk_b("rst_lcd_cs", o_lcd_cs, 1'b1);
        chk_b("rst_sw_cs", o_sw_cs, 1'b1);
        chk_b("rst_start", o_spi_start, 1'b0);
        chk_b("rst_lcd_done", o_lcd_done, 1'b0);
        chk_b("rst_sw_done", o_sw_done, 1'b0);
        chk_b("rst_busy", o_busy, 1'b0);
        chk_b("rst_err", o_timeout_err, 1'b0);
        chk_w("rst_mosi", o_mosi_data, 24'h0);
        chk_w("rst_rx", o_rx_data, 24'h0);
    endtask

    // One transaction with the bench acting as SPI master. to_mode: CS never
    // drops. scramble: requests and mosi inputs change once the arbiter is busy.
    task automatic do_txn(input logic own, input logic [23:0] exp_mosi, input int low_cyc,
                          input logic [23:0] miso, input bit to_mode, input bit scramble,
                          input bit keep_req, output int t_start, output int t_done);
        bit seen     = 1'b0;
        bit got_done = 1'b0;
        int budget;
        t_start     = -1;
        t_done      = -1;
        i_miso_data = miso;
        for (int n = 0; n < 64 && !seen; n++) begin
            step();
            if (o_spi_start === 1'b1) seen = 1'b1;
            else if (scramble && o_busy === 1'b1) begin
                i_lcd_mosi = 24'hFFFFFF;
                i_sw_mosi  = 24'hFFFFFF;
                i_lcd_req  = 1'b0;
                i_sw_req   = 1'b0;
            end
        end
        chk_b("start_seen", seen, 1'b1);
        if (!seen) return;
        t_start = cyc;
        chk_w("start_mosi", o_mosi_data, exp_mosi);
        chk_b("start_busy", o_busy, 1'b1);
        i_spi_cs = to_mode;
        if (!to_mode) begin
            for (int k = 0; k < low_cyc; k++) begin
                step();
                chk_b("start_single", o_spi_start, 1'b0);
                chk_b("owner_cs_follows", own ? o_sw_cs : o_lcd_cs, 1'b0);
                chk_b("other_cs_high", own ? o_lcd_cs : o_sw_cs, 1'b1);
                chk_b("no_early_done", o_lcd_done | o_sw_done, 1'b0);
                chk_w("mosi_hold", o_mosi_data, exp_mosi);
            end
            i_spi_cs = 1'b1;
        end
        budget = to_mode ? TO + 8 : 8;
        for (int n = 0; n < budget && !got_done; n++) begin
            step();
            if ((o_lcd_done | o_sw_done) === 1'b1) got_done = 1'b1;
            else begin
                chk_b("start_single", o_spi_start, 1'b0);
                chk_w("mosi_hold", o_mosi_data, exp_mosi);
            end
        end
        chk_b("done_seen", got_done, 1'b1);
        if (!got_done) return;
        t_done = cyc;
        chk_i("done_latency", t_done - t_start, to_mode ? TO + 1 : low_cyc + 1);
        chk_b("done_owner", own ? o_sw_done : o_lcd_done, 1'b1);
        chk_b("done_other", own ? o_lcd_done : o_sw_done, 1'b0);
        chk_w("rx_data", o_rx_data, to_mode ? 24'h0 : miso);
        chk_b("done_lcd_cs", o_lcd_cs, 1'b1);
        chk_b("done_sw_cs", o_sw_cs, 1'b1);
        if (to_mode) chk_b("timeout_err_set", o_timeout_err, 1'b1);
        if (!keep_req) begin
            i_lcd_req = 1'b0;
            i_sw_req  = 1'b0;
        end
        step();
        chk_b("done_pulse_width", o_lcd_done | o_sw_done, 1'b0);
        chk_w("rx_held", o_rx_data, to_mode ? 24'h0 : miso);
    endtask

    initial begin
        int          ts, td, ts2, td1, pat, low;
        logic        l, s, exp_own, m_last;
        logic [23:0] lm, sm, miso;
        bit          seen;

        i_rst       = 1'b0;
        i_lcd_req   = 1'b0;
        i_sw_req    = 1'b0;
        i_lcd_mosi  = 24'h0;
        i_sw_mosi   = 24'h0;
        i_miso_data = 24'h0;
        i_spi_cs    = 1'b1;
        i_err_clear = 1'b0;
        repeat (3) step();
        check_reset_state();
        i_rst = 1'b1;

        // Single LCD transaction
        i_lcd_mosi = 24'hA5A5A5;
        i_lcd_req  = 1'b1;
        do_txn(c_id_lcd, 24'hA5A5A5, 30, 24'h123456, 1'b0, 1'b0, 1'b0, ts, td);

        // Tie from reset: LCD first, then SW after the enforced gap
        repeat (GAP + 3) step();
        i_rst      = 1'b0;
        i_lcd_req  = 1'b1;
        i_sw_req   = 1'b1;
        i_lcd_mosi = 24'h111111;
        i_sw_mosi  = 24'h222222;
        repeat (2) step();
        check_reset_state();
        i_rst  = 1'b1;
        m_last = c_id_sw;
        exp_own = ref_pick(1'b1, 1'b1, m_last);
        m_last  = exp_own;
        do_txn(exp_own, 24'h111111, 5, 24'hABCDEF, 1'b0, 1'b0, 1'b1, ts, td1);
        exp_own = ref_pick(1'b1, 1'b1, m_last);
        m_last  = exp_own;
        do_txn(exp_own, 24'h222222, 7, 24'h0F0F0F, 1'b0, 1'b0, 1'b0, ts2, td);
        chk_i("rr_gap_to_next_start", ts2 - td1, GAP + 3);

        // Randomized transactions against the reference model
        for (int it = 0; it < 10; it++) begin
            repeat (GAP + 3) step();
            chk_b("idle_before_req", o_busy, 1'b0);
            pat  = int'($urandom_range(1, 3));
            l    = (pat & 1) != 0;
            s    = (pat & 2) != 0;
            lm   = 24'($urandom);
            sm   = 24'($urandom);
            miso = 24'($urandom);
            low  = int'($urandom_range(2, 20));
            exp_own    = ref_pick(l, s, m_last);
            m_last     = exp_own;
            i_lcd_mosi = lm;
            i_sw_mosi  = sm;
            i_lcd_req  = l;
            i_sw_req   = s;
            do_txn(exp_own, exp_own ? sm : lm, low, miso, 1'b0, 1'b0, 1'b0, ts, td);
        end

        // mosi and request changes after LOAD are ignored
        repeat (GAP + 3) step();
        i_sw_mosi  = 24'h000001;
        i_lcd_mosi = 24'h000000;
        i_sw_req   = 1'b1;
        do_txn(c_id_sw, 24'h000001, 10, 24'h00BEEF, 1'b0, 1'b1, 1'b0, ts, td);

        // Timeout in WAIT_LOW, then clear
        repeat (GAP + 3) step();
        i_lcd_mosi = 24'hC0FFEE;
        i_lcd_req  = 1'b1;
        do_txn(c_id_lcd, 24'hC0FFEE, 0, 24'hDEAD00, 1'b1, 1'b0, 1'b0, ts, td);
        chk_b("timeout_err_sticky", o_timeout_err, 1'b1);
        i_err_clear = 1'b1;
        step();
        chk_b("timeout_err_cleared", o_timeout_err, 1'b0);
        i_err_clear = 1'b0;

        // Timeout with clear held high: set wins, clear acts afterwards
        repeat (GAP + 3) step();
        i_err_clear = 1'b1;
        i_sw_mosi   = 24'h777777;
        i_sw_req    = 1'b1;
        do_txn(c_id_sw, 24'h777777, 0, 24'h999999, 1'b1, 1'b0, 1'b0, ts, td);
        chk_b("err_clear_after_set", o_timeout_err, 1'b0);
        i_err_clear = 1'b0;

        // Reset during WAIT_HIGH of a switch transaction
        repeat (GAP + 3) step();
        i_sw_mosi = 24'h5A5A5A;
        i_sw_req  = 1'b1;
        seen      = 1'b0;
        for (int n = 0; n < 16 && !seen; n++) begin
            step();
            if (o_spi_start === 1'b1) seen = 1'b1;
        end
        chk_b("rst_txn_start_seen", seen, 1'b1);
        i_spi_cs = 1'b0;
        step();
        step();
        chk_b("rst_txn_busy", o_busy, 1'b1);
        chk_b("rst_txn_sw_cs", o_sw_cs, 1'b0);
        i_rst    = 1'b0;
        i_sw_req = 1'b0;
        step();
        chk_b("abort_busy", o_busy, 1'b0);
        chk_b("abort_lcd_cs", o_lcd_cs, 1'b1);
        chk_b("abort_sw_cs", o_sw_cs, 1'b1);
        chk_b("abort_sw_done", o_sw_done, 1'b0);
        chk_b("abort_start", o_spi_start, 1'b0);
        i_spi_cs = 1'b1;
        repeat (2) begin
            step();
            chk_b("abort_no_done_in_rst", o_lcd_done | o_sw_done, 1'b0);
        end
        i_rst = 1'b1;
        repeat (GAP + 3) begin
            step();
            chk_b("abort_no_done_after", o_lcd_done | o_sw_done, 1'b0);
            chk_b("abort_stays_idle", o_busy, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no completion required completion within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/front_spi_arb.md
FRONT_SPI_ARB -- requirements
Module: front_spi_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1024, meaning the maximum cycles allowed in either CS-wait state.
REQ-002 SHALL have parameter GAP_CYC, default 4, meaning the idle cycles enforced between consecutive SPI transactions (minimum 1).
REQ-003 SHALL have port i_clk  input  1  system clock; the only clock in the block.
REQ-004 SHALL have port i_rst  input  1  synchronous active-low reset.
REQ-005 SHALL have port i_lcd_req  input  1  LCD requester transaction request, level, held until done.
REQ-006 SHALL have port i_lcd_mosi  input  24  LCD transmit word.
REQ-007 SHALL have port o_lcd_done  output  1  one-cycle pulse when the LCD transaction ends.
REQ-008 SHALL have port i_sw_req  input  1  switch requester transaction request, level, held until done.
REQ-009 SHALL have port i_sw_mosi  input  24  switch transmit word.
REQ-010 SHALL have port o_sw_done  output  1  one-cycle pulse when the switch transaction ends.
REQ-011 SHALL have port o_rx_data  output  24  received word, valid in the done cycle and held until the next done.
REQ-012 SHALL have port o_spi_start  output  1  one-cycle start pulse to the SPI master.
REQ-013 SHALL have port o_mosi_data  output  24  word to the SPI master.
REQ-014 SHALL have port i_miso_data  input  24  word from the SPI master.
REQ-015 SHALL have port i_spi_cs  input  1  SPI master chip select, active-low.
REQ-016 SHALL have port o_lcd_cs  output  1  LCD chip select, active-low.
REQ-017 SHALL have port o_sw_cs  output  1  switch chip select, active-low.
REQ-018 SHALL have port o_busy  output  1  high whenever the FSM is not in IDLE.
REQ-019 SHALL have port o_timeout_err  output  1  sticky timeout flag.
REQ-020 SHALL have port i_err_clear  input  1  clears o_timeout_err.

Function
REQ-021 SHALL implement the FSM states IDLE, LOAD, START, WAIT_LOW, WAIT_HIGH, DONE and GAP.
REQ-022 SHALL move from IDLE to LOAD when either request is high, latching the owner and that owner's mosi word into o_mosi_data.
REQ-023 SHALL arbitrate round-robin: when both requests are high, the requester not served last wins; after reset the switch requester is treated as served last, so the LCD requester wins the first tie.
REQ-024 SHALL pass LOAD to START in 1 cycle and assert o_spi_start only in START, for exactly 1 cycle, then go to WAIT_LOW.
REQ-025 SHALL go WAIT_LOW to WAIT_HIGH when i_spi_cs=0, and WAIT_HIGH to DONE when i_spi_cs=1.
REQ-026 SHALL, in DONE, capture i_miso_data into o_rx_data, pulse the owner's done output for 1 cycle, then go to GAP.
REQ-027 SHALL stay in GAP for exactly GAP_CYC cycles, then return to IDLE.
REQ-028 SHALL treat a request still high in the cycle after its done pulse as a new request.
REQ-029 SHALL, in LOAD through WAIT_HIGH, drive the owner's CS = i_spi_cs and hold the non-owner's CS at 1.
REQ-030 SHALL hold both CS outputs at 1 in IDLE, DONE and GAP.
REQ-031 SHALL reset a timeout counter on entry to WAIT_LOW and to WAIT_HIGH and increment it each cycle in those states.
REQ-032 SHALL, when the timeout counter reaches TIMEOUT_CYC-1, set o_timeout_err, go to DONE with o_rx_data=0, and still pulse the owner's done.
REQ-033 SHALL make set win over i_err_clear when both occur in the same cycle.
REQ-034 SHALL ignore request deassertion after LOAD: the transaction completes regardless.
REQ-035 SHALL ignore changes on the mosi inputs after LOAD.
REQ-036 SHALL never assert both CS outputs low in the same cycle.

Reset
REQ-037 SHALL, while i_rst=0 at a clock edge, force state IDLE; o_lcd_cs=o_sw_cs=1; o_spi_start=0; o_lcd_done=o_sw_done=0; o_busy=0; o_timeout_err=0; o_mosi_data=0; o_rx_data=0; counters 0; last-served=switch.
REQ-038 SHALL abandon any in-flight transaction on reset, with no done pulse issued.

Structure
REQ-039 SHALL keep the state encoding, the requester ID constants (LCD=0, SW=1) and the default TIMEOUT_CYC/GAP_CYC values in the shared front-panel package.
REQ-040 SHALL place the round-robin grant logic in one sub-module, front_rr_arb2, with inputs req[1:0] and last, and output grant ID.

Verification
REQ-041 SHALL cover: LCD req with mosi 0xA5A5A5, SPI model holds CS low for 30 cycles and returns 0x123456 -> one start pulse, o_lcd_cs follows CS, o_sw_cs stays 1, o_lcd_done pulses, o_rx_data=0x123456.
REQ-042 SHALL cover: both requests high from reset, held through two transactions -> LCD served first, then SW, separated by ≥4 idle cycles with both CS=1.
REQ-043 SHALL cover: SPI model never drops CS after start -> o_timeout_err set at cycle 1023 of WAIT_LOW, done pulses, o_rx_data=0; i_err_clear then clears it.
REQ-044 SHALL cover: reset asserted during WAIT_HIGH of an SW transaction -> next cycle IDLE, both CS=1, no o_sw_done.
REQ-045 SHALL cover: i_sw_mosi changed from 0x000001 to 0xFFFFFF one cycle after LOAD -> o_mosi_data stays 0x000001 for the whole transaction.
